// File: rtl/key_matrix_scanner_pkg.sv
// Shared keyboard types: scan FSM states, event record and
// the default key indices that switch the ISA.
package key_matrix_scanner_pkg;

    localparam int KEY_CODE_W    = 8;
    localparam int ISA_F_KEY_DEF = 15;
    localparam int ISA_E_KEY_DEF = 14;

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_DRIVE,
        SCAN_SAMPLE
    } scan_state_e;

    typedef struct packed {
        logic [KEY_CODE_W-1:0] code;
        logic                  pressed;
    } key_event_t;

endpackage

// File: rtl/key_event_fifo.sv
// Registered (no-fall-through) event FIFO with valid/ready output
// and a full flag; pushes while full are ignored unless popping.
module key_event_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CNTW-1:0]  cnt_q;
    logic             pop;
    logic             wr;

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == CNTW'(DEPTH));
    assign pop     = valid_o && ready_i;
    assign wr      = push_i && (!full_o || pop);
    // Idle head reads as zero so an empty FIFO presents code 0.
    assign data_o  = valid_o ? mem_q[rptr_q] : '0;

    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (wr && !pop) begin
                cnt_q <= cnt_q + CNTW'(1);
            end else if (pop && !wr) begin
                cnt_q <= cnt_q - CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/key_matrix_scanner.sv
// Column-strobed key matrix scanner: per-key debounce, press/release
// event FIFO, sticky overflow and ISA select from two hot keys.
module key_matrix_scanner
    import key_matrix_scanner_pkg::*;
#(
    parameter int COLS           = 8,
    parameter int ROWS           = 5,
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 8,
    parameter int ISA_F_KEY      = ISA_F_KEY_DEF,
    parameter int ISA_E_KEY      = ISA_E_KEY_DEF,
    localparam int NKEYS         = COLS * ROWS,
    localparam int CW            = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             scanEn,
    input  logic [ROWS-1:0]  kbRow,
    output logic [COLS-1:0]  kbCol,
    output logic [NKEYS-1:0] keysState,
    output logic             evValid,
    input  logic             evReady,
    output logic [CW-1:0]    evCode,
    output logic             evPressed,
    output logic             overflow,
    input  logic             clearOverflow,
    output logic             BFISA
);

    localparam int COLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DBW  = $clog2(DEBOUNCE_SCANS + 1);

    scan_state_e      state_q;
    logic [COLW-1:0]  col_q;
    logic [RW-1:0]    row_q;
    logic [SW-1:0]    settle_q;
    logic [COLS-1:0]  kbCol_q;
    logic [ROWS-1:0]  rows_q;
    logic [NKEYS-1:0] keys_q;
    logic [DBW-1:0]   dbCnt_q [NKEYS];
    logic             overflow_q;
    logic             bfisa_q;

    logic [COLW-1:0]  col_d;
    logic [CW-1:0]    keyIdx;
    logic [DBW-1:0]   cntInc;
    logic             sampling;
    logic             sampleBit;
    logic             stableBit;
    logic             flip;
    logic             fifoFull;
    logic             drop;
    key_event_t       evIn;
    key_event_t       evHead;

    assign col_d = (col_q == COLW'(COLS - 1)) ? '0 : col_q + COLW'(1);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= SCAN_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            settle_q <= '0;
            kbCol_q  <= '0;
            rows_q   <= '0;
        end else begin
            unique case (state_q)
                SCAN_IDLE: begin
                    if (scanEn) begin
                        state_q  <= SCAN_DRIVE;
                        settle_q <= '0;
                        kbCol_q  <= COLS'(1) << col_q;
                    end
                end
                SCAN_DRIVE: begin
                    if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                        state_q <= SCAN_SAMPLE;
                        row_q   <= '0;
                        rows_q  <= kbRow;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                SCAN_SAMPLE: begin
                    if (row_q == RW'(ROWS - 1)) begin
                        col_q    <= col_d;
                        settle_q <= '0;
                        if (scanEn) begin
                            state_q <= SCAN_DRIVE;
                            kbCol_q <= COLS'(1) << col_d;
                        end else begin
                            state_q <= SCAN_IDLE;
                            kbCol_q <= '0;
                        end
                    end else begin
                        row_q <= row_q + RW'(1);
                    end
                end
                default: begin
                    state_q <= SCAN_IDLE;
                    kbCol_q <= '0;
                end
            endcase
        end
    end

    // One key is examined per SAMPLE cycle, so at most one flip per cycle.
    assign sampling  = (state_q == SCAN_SAMPLE);
    assign keyIdx    = CW'(int'(col_q) * ROWS + int'(row_q));
    assign sampleBit = rows_q[row_q];
    assign stableBit = keys_q[keyIdx];
    assign cntInc    = dbCnt_q[keyIdx] + DBW'(1);
    assign flip      = sampling && (sampleBit != stableBit)
                       && (cntInc == DBW'(DEBOUNCE_SCANS));
    assign drop      = flip && fifoFull && !(evValid && evReady);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            keys_q <= '0;
            for (int k = 0; k < NKEYS; k++) begin
                dbCnt_q[k] <= '0;
            end
            overflow_q <= 1'b0;
            bfisa_q    <= 1'b1;
        end else begin
            if (sampling) begin
                if (sampleBit == stableBit) begin
                    dbCnt_q[keyIdx] <= '0;
                end else if (flip) begin
                    dbCnt_q[keyIdx] <= '0;
                    keys_q[keyIdx]  <= sampleBit;
                end else begin
                    dbCnt_q[keyIdx] <= cntInc;
                end
            end
            if (flip && sampleBit) begin
                if (keyIdx == CW'(ISA_F_KEY)) begin
                    bfisa_q <= 1'b1;
                end else if (keyIdx == CW'(ISA_E_KEY)) begin
                    bfisa_q <= 1'b0;
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clearOverflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign evIn = '{code: KEY_CODE_W'(keyIdx), pressed: sampleBit};

    key_event_fifo #(
        .WIDTH ($bits(key_event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_ni  (Rst_n),
        .push_i  (flip),
        .data_i  (evIn),
        .full_o  (fifoFull),
        .valid_o (evValid),
        .ready_i (evReady),
        .data_o  (evHead)
    );

    assign kbCol     = kbCol_q;
    assign keysState = keys_q;
    assign evCode    = CW'(evHead.code);
    assign evPressed = evHead.pressed;
    assign overflow  = overflow_q;
    assign BFISA     = bfisa_q;

endmodule

// File: doc/key_matrix_scanner.md
KEY_MATRIX_SCANNER -- requirements
Module: key_matrix_scanner

Interface
REQ-001 SHALL have parameter COLS, default 8, the number of matrix columns driven.
REQ-002 SHALL have parameter ROWS, default 5, the number of matrix rows sampled.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4, the column-drive cycles before sampling (minimum 1).
REQ-004 SHALL have parameter DEBOUNCE_SCANS, default 3, the consecutive disagreeing scans needed to flip a key (minimum 1).
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, the event FIFO entries (power of two).
REQ-006 SHALL have parameters ISA_F_KEY, default 15, and ISA_E_KEY, default 14, the key indices that select the ISA.
REQ-007 SHALL have the ports listed below. One clock; reset is asynchronous and active-low.
- Clk  in  1  clock.
- Rst_n  in  1  asynchronous active-low reset.
- scanEn  in  1  enables scanning.
- kbRow  in  ROWS  row sense inputs, active-high.
- kbCol  out  COLS  one-hot column strobe.
- keysState  out  COLS*ROWS  debounced key states; key index = col*ROWS+row.
- evValid  out  1  event available.
- evReady  in  1  consumer accepts the event.
- evCode  out  clog2(COLS*ROWS)  key index of the head event.
- evPressed  out  1  head event is a press (1) or a release (0).
- overflow  out  1  sticky flag: an event was dropped.
- clearOverflow  in  1  one-cycle clear of overflow.
- BFISA  out  1  ISA select: 1 = Brainfuck, 0 = maintenance.

Function
REQ-008 SHALL implement the scan FSM IDLE -> DRIVE -> SAMPLE -> (DRIVE for the next column | IDLE).
- IDLE: kbCol=0; leave for DRIVE when scanEn=1.
REQ-009 SHALL hold DRIVE for exactly SETTLE_CYCLES cycles, with kbCol one-hot at the current column.
REQ-010 SHALL latch kbRow on SAMPLE entry; SAMPLE then processes rows 0..ROWS-1, one row per cycle.
- kbCol stays asserted throughout SAMPLE.
REQ-011 SHALL, after the last row, advance the column, wrapping COLS-1 -> 0.
- If scanEn=0, go to IDLE; otherwise go to DRIVE.
- The full scan period is COLS*(SETTLE_CYCLES+ROWS) cycles.
REQ-012 SHALL, in deasserted scanEn mid-scan, complete the current SAMPLE before returning to IDLE; the column index is retained.
REQ-013 SHALL give each key a debounce counter.
- Sample equals stable state: counter cleared.
- Sample differs: counter incremented.
- On reaching DEBOUNCE_SCANS: stable state flips, counter clears, and one event {index, newState} is generated in that cycle.
REQ-014 SHALL generate at most one event per cycle; this is guaranteed by row serialisation.
REQ-015 SHALL implement the FIFO as no-fall-through: a push into an empty FIFO raises evValid on the next cycle.
REQ-016 SHALL pop when evValid && evReady.
- evCode and evPressed stay stable while evValid=1 and evReady=0.
REQ-017 SHALL, on a push while the FIFO is full and not popping:
- drop the event;
- set overflow;
- still update keysState.
REQ-018 SHALL accept a simultaneous push and pop when full, without setting overflow.
REQ-019 SHALL clear overflow on clearOverflow=1; if overflow is set in the same cycle, set wins.
REQ-020 SHALL update BFISA only on debounced press events: ISA_F_KEY sets it to 1, ISA_E_KEY sets it to 0.
- Releases and held keys do not change BFISA.
- BFISA updates even when the event is dropped.

Reset
REQ-021 SHALL, while Rst_n=0, immediately force all of the following:
- FSM to IDLE; column index 0; kbCol=0;
- keysState=0; all debounce counters 0;
- FIFO empty: evValid=0, evCode=0, evPressed=0;
- overflow=0; BFISA=1.
REQ-022 SHALL discard any in-progress scan and queued events on reset mid-operation.

Structure
REQ-023 SHALL keep the FSM state enum, the event record type (code, pressed) and the default ISA key indices in the shared keyboard package.
REQ-024 SHALL instantiate the event FIFO as sub-module key_event_fifo (parametrised WIDTH and DEPTH, valid/ready output, full flag).

Verification
REQ-025 SHALL check scan timing under default parameters, scanEn=1:
- kbCol walks 0x01 -> 0x02 -> ... -> 0x80 -> 0x01;
- each column is asserted 9 cycles;
- the period is 72 cycles.
REQ-026 SHALL check debounce of key 7 (col 1, row 2) held for 3 scans:
- exactly one event, evCode=7, evPressed=1, after the third sample;
- a 2-scan glitch produces no event.
REQ-027 SHALL check backpressure: with evReady=0, generate 9 press events.
- The FIFO holds 8 events; the 9th is dropped and overflow=1.
- Raising evReady drains the 8 events in order.
- clearOverflow returns overflow to 0.
REQ-028 SHALL check ISA select:
- press key 14 -> BFISA=0;
- release it -> BFISA stays 0;
- press key 15 -> BFISA=1.
REQ-029 SHALL check reset mid-operation: pulse Rst_n low during DRIVE of column 3 with 4 queued events.
- All outputs take reset values.
- The scan restarts at column 0 when scanEn=1.
REQ-030 SHALL check a simultaneous push and pop on a full FIFO: the count stays 8 and overflow stays 0.
